// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor: FSM state encoding, default
// parameter values and the helper that sizes saturating counters so they can
// hold their terminal value.
// Ports: none (package).
// Configuration macro used elsewhere: PLL_SUP_LOSS_CNT_EN.
// -----------------------------------------------------------------------------
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEED     = 3'd1,
        ST_ACQUIRE  = 3'd2,
        ST_TRACK    = 3'd3,
        ST_HOLDOVER = 3'd4
    } state_t;

    // Width needed for a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_INCR_W       = 17;
    localparam int DEF_INCR_MIN     = 400;
    localparam int DEF_INCR_MAX     = 800;
    localparam int DEF_INCR_STEP    = 25;
    localparam int DEF_ACQ_EDGES    = 64;
    localparam int DEF_LOCK_EDGES   = 16;
    localparam int DEF_UNLOCK_EDGES = 4;
    localparam int DEF_EDGE_TIMEOUT = 2**20;

    localparam int DEF_ACQ_CNT_W = $clog2(DEF_ACQ_EDGES + 1);
    localparam int DEF_LK_CNT_W  = $clog2(DEF_LOCK_EDGES + 1);
    localparam int DEF_UL_CNT_W  = $clog2(DEF_UNLOCK_EDGES + 1);
    localparam int DEF_TO_CNT_W  = $clog2(DEF_EDGE_TIMEOUT + 1);

    localparam int LOSS_CNT_W = 16;

endpackage

// File: rtl/ref_edge_sync.sv
// -----------------------------------------------------------------------------
// ref_edge_sync
// Two-flop synchroniser for the asynchronous reference pin followed by a
// registered rising-edge strobe. The strobe is high for one clk, three clk
// after the pin rises.
// Ports:
//   i_clk    in  system clock
//   i_rst    in  asynchronous active-high reset
//   i_ref_in in  raw reference pin (asynchronous)
//   o_edge   out one-cycle rising-edge strobe
// -----------------------------------------------------------------------------
module ref_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ref_in,
    output logic o_edge
);

    logic r_q1;
    logic r_q2;
    logic r_edge;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q1   <= 1'b0;
            r_q2   <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_q1   <= i_ref_in;
            r_q2   <= r_q1;
            r_edge <= r_q1 & ~r_q2;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences the dithered PLL core: loads a phase-increment seed, sweeps seeds
// until lock qualifies, selects coarse/fine loop gain, detects loss of lock
// and reference dropout (holdover).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE     0  | first cycle after reset release
// SEED     1  | one-cycle seed load pulse to the PLL
// ACQUIRE  2  | coarse gain, counting consecutive locked reference edges
// TRACK    3  | fine gain, lock_ok, counting consecutive unlocked edges
// HOLDOVER 4  | reference lost, PLL increment frozen until next edge
//
// Ports:
//   i_clk, i_rst    system clock, asynchronous active-high reset
//   i_ref_in        raw reference pin (asynchronous)
//   i_pll_locked    per-cycle lock flag from the PLL core
//   o_pll_seed      signed increment word for the PLL
//   o_pll_seed_ld   one-cycle load strobe for o_pll_seed
//   o_pll_hold      PLL holdover request
//   o_pll_fine      0 = coarse, 1 = fine loop gain
//   o_lock_ok       qualified lock
//   o_state         current FSM state (debug)
//   o_loss_cnt      lock-loss counter, only when PLL_SUP_LOSS_CNT_EN is defined
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int INCR_W       = DEF_INCR_W,
    parameter int INCR_MIN     = DEF_INCR_MIN,
    parameter int INCR_MAX     = DEF_INCR_MAX,
    parameter int INCR_STEP    = DEF_INCR_STEP,
    parameter int ACQ_EDGES    = DEF_ACQ_EDGES,
    parameter int LOCK_EDGES   = DEF_LOCK_EDGES,
    parameter int UNLOCK_EDGES = DEF_UNLOCK_EDGES,
    parameter int EDGE_TIMEOUT = DEF_EDGE_TIMEOUT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ref_in,
    input  logic                     i_pll_locked,
    output logic signed [INCR_W-1:0] o_pll_seed,
    output logic                     o_pll_seed_ld,
    output logic                     o_pll_hold,
    output logic                     o_pll_fine,
    output logic                     o_lock_ok,
    output logic [2:0]               o_state
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0]    o_loss_cnt
`endif
);

    localparam int C_ACQ_W = cnt_width(ACQ_EDGES);
    localparam int C_LK_W  = cnt_width(LOCK_EDGES);
    localparam int C_UL_W  = cnt_width(UNLOCK_EDGES);
    localparam int C_TO_W  = cnt_width(EDGE_TIMEOUT);

    localparam logic [C_ACQ_W-1:0] C_ACQ_MAX = C_ACQ_W'(ACQ_EDGES);
    localparam logic [C_LK_W-1:0]  C_LK_MAX  = C_LK_W'(LOCK_EDGES);
    localparam logic [C_UL_W-1:0]  C_UL_MAX  = C_UL_W'(UNLOCK_EDGES);
    localparam logic [C_TO_W-1:0]  C_TO_MAX  = C_TO_W'(EDGE_TIMEOUT);
    localparam logic [C_TO_W-1:0]  C_TO_LAST = C_TO_W'(EDGE_TIMEOUT - 1);

    localparam logic signed [INCR_W-1:0] C_SEED_MIN   = INCR_W'(INCR_MIN);
    localparam logic signed [INCR_W:0]   C_SEED_MAX_X = (INCR_W+1)'(INCR_MAX);

    logic                     w_edge;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_state_chg;
    logic                     w_in_run;
    logic                     w_timeout;

    logic [C_ACQ_W-1:0]       r_edge_cnt;
    logic [C_LK_W-1:0]        r_lk_cnt;
    logic [C_UL_W-1:0]        r_ul_cnt;
    logic [C_TO_W-1:0]        r_to_cnt;
    logic [C_ACQ_W-1:0]       w_edge_cnt_nxt;
    logic [C_LK_W-1:0]        w_lk_nxt;
    logic [C_UL_W-1:0]        w_ul_nxt;
    logic [C_TO_W-1:0]        w_to_nxt;

    logic signed [INCR_W-1:0] r_seed;
    logic signed [INCR_W:0]   w_seed_sum;
    logic signed [INCR_W-1:0] w_seed_wrap;

    ref_edge_sync u_ref_edge_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ref_in (i_ref_in),
        .o_edge   (w_edge)
    );

    // Saturating next values; applied only on edge cycles in the owning state.
    always_comb begin
        w_lk_nxt = '0;
        if (i_pll_locked)
            w_lk_nxt = (r_lk_cnt >= C_LK_MAX) ? r_lk_cnt : r_lk_cnt + 1'b1;
        w_ul_nxt = '0;
        if (!i_pll_locked)
            w_ul_nxt = (r_ul_cnt >= C_UL_MAX) ? r_ul_cnt : r_ul_cnt + 1'b1;
        w_edge_cnt_nxt = (r_edge_cnt >= C_ACQ_MAX) ? r_edge_cnt : r_edge_cnt + 1'b1;
        w_to_nxt       = (r_to_cnt >= C_TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
    end

    // One bit of headroom so the step past INCR_MAX cannot overflow the seed.
    assign w_seed_sum  = {r_seed[INCR_W-1], r_seed} + (INCR_W+1)'(INCR_STEP);
    assign w_seed_wrap = (w_seed_sum > C_SEED_MAX_X) ? C_SEED_MIN : w_seed_sum[INCR_W-1:0];

    assign w_in_run  = (r_state == ST_ACQUIRE) || (r_state == ST_TRACK);
    // Fires on the EDGE_TIMEOUT-th consecutive edgeless cycle.
    assign w_timeout = w_in_run && !w_edge && (r_to_cnt >= C_TO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     w_state_nxt = ST_SEED;
            ST_SEED:     w_state_nxt = ST_ACQUIRE;
            ST_ACQUIRE: begin
                // Dropout outranks the lock/window decisions.
                if (w_timeout)
                    w_state_nxt = ST_HOLDOVER;
                else if (w_edge && (w_lk_nxt == C_LK_MAX))
                    w_state_nxt = ST_TRACK;
                else if (w_edge && (w_edge_cnt_nxt == C_ACQ_MAX))
                    w_state_nxt = ST_SEED;
            end
            ST_TRACK: begin
                if (w_timeout)
                    w_state_nxt = ST_HOLDOVER;
                else if (w_edge && (w_ul_nxt == C_UL_MAX))
                    w_state_nxt = ST_ACQUIRE;
            end
            ST_HOLDOVER: if (w_edge) w_state_nxt = ST_SEED;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    always_comb begin
        o_pll_seed_ld = 1'b0;
        o_pll_hold    = 1'b0;
        o_pll_fine    = 1'b0;
        o_lock_ok     = 1'b0;
        case (r_state)
            ST_SEED:     o_pll_seed_ld = 1'b1;
            ST_TRACK: begin
                o_pll_fine = 1'b1;
                o_lock_ok  = 1'b1;
            end
            ST_HOLDOVER: o_pll_hold    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_edge_cnt <= '0;
            r_lk_cnt   <= '0;
            r_ul_cnt   <= '0;
            r_to_cnt   <= '0;
            r_seed     <= C_SEED_MIN;
        end else begin
            if (w_state_chg) begin
                r_lk_cnt <= '0;
                r_ul_cnt <= '0;
                r_to_cnt <= '0;
            end else begin
                if (r_state == ST_ACQUIRE && w_edge) r_lk_cnt <= w_lk_nxt;
                if (r_state == ST_TRACK && w_edge)   r_ul_cnt <= w_ul_nxt;
                if (w_in_run)                        r_to_cnt <= w_edge ? '0 : w_to_nxt;
            end

            // Window progress survives TRACK excursions; only a new seed restarts it.
            if (w_state_nxt == ST_SEED && r_state != ST_SEED)
                r_edge_cnt <= '0;
            else if (r_state == ST_ACQUIRE && w_edge)
                r_edge_cnt <= w_edge_cnt_nxt;

            if (r_state == ST_ACQUIRE && w_state_nxt == ST_SEED)
                r_seed <= w_seed_wrap;
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_loss_cnt <= '0;
        else if (r_state == ST_TRACK && w_state_chg && (r_loss_cnt != '1))
            r_loss_cnt <= r_loss_cnt + 1'b1;
    end

    assign o_loss_cnt = r_loss_cnt;
`endif

    assign o_pll_seed = r_seed;
    assign o_state    = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Self-checking bench: a behavioural model of the supervisor rules is stepped
// every clk and compared with the DUT on every falling edge; directed phases
// pin the model with hand-computed values, then randomized reference/lock
// traffic runs against the model. Timing parameters are shortened.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int P_W    = 17;
    localparam int P_MIN  = 400;
    localparam int P_MAX  = 800;
    localparam int P_STEP = 25;
    localparam int P_ACQ  = 20;
    localparam int P_LOCK = 16;
    localparam int P_UL   = 4;
    localparam int P_TO   = 200;

    localparam int S_IDLE = 0, S_SEED = 1, S_ACQ = 2, S_TRACK = 3, S_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ref_in = 1'b0;
    logic pll_locked = 1'b0;
    logic signed [P_W-1:0] seed;
    logic seed_ld, hold, fine, lock_ok;
    logic [2:0] state;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [15:0] loss_cnt;
`endif

    pll_lock_supervisor #(
        .INCR_W(P_W), .INCR_MIN(P_MIN), .INCR_MAX(P_MAX), .INCR_STEP(P_STEP),
        .ACQ_EDGES(P_ACQ), .LOCK_EDGES(P_LOCK), .UNLOCK_EDGES(P_UL), .EDGE_TIMEOUT(P_TO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ref_in      (ref_in),
        .i_pll_locked  (pll_locked),
        .o_pll_seed    (seed),
        .o_pll_seed_ld (seed_ld),
        .o_pll_hold    (hold),
        .o_pll_fine    (fine),
        .o_lock_ok     (lock_ok),
        .o_state       (state)
`ifdef PLL_SUP_LOSS_CNT_EN
        ,
        .o_loss_cnt    (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int m_st, m_lk, m_ul, m_edges, m_to, m_seed, m_loss;
    bit h0, h1, h2;   // pin samples at the last three clocks, newest first

    function automatic void model_reset();
        m_st = S_IDLE; m_lk = 0; m_ul = 0; m_edges = 0; m_to = 0;
        m_seed = P_MIN; m_loss = 0;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    endfunction

    function automatic void model_step();
        bit e;
        int nxt;
        if (rst) begin
            model_reset();
            return;
        end
        // The FSM acts on a rise the pin showed two samples before this clock.
        e   = h1 && !h2;
        nxt = m_st;
        case (m_st)
            S_IDLE: nxt = S_SEED;
            S_SEED: nxt = S_ACQ;
            S_ACQ, S_TRACK: begin
                if (!e) begin
                    if (m_to + 1 >= P_TO) nxt = S_HOLD;
                    else m_to++;
                end else begin
                    m_to = 0;
                    if (m_st == S_ACQ) begin
                        m_lk = pll_locked ? ((m_lk < P_LOCK) ? m_lk + 1 : m_lk) : 0;
                        if (m_edges < P_ACQ) m_edges++;
                        if (m_lk == P_LOCK) nxt = S_TRACK;
                        else if (m_edges == P_ACQ) begin
                            m_seed = (m_seed + P_STEP > P_MAX) ? P_MIN : m_seed + P_STEP;
                            nxt = S_SEED;
                        end
                    end else begin
                        m_ul = pll_locked ? 0 : m_ul + 1;
                        if (m_ul >= P_UL) nxt = S_ACQ;
                    end
                end
            end
            S_HOLD: if (e) nxt = S_SEED;
            default: nxt = S_IDLE;
        endcase
        if (m_st == S_TRACK && nxt != S_TRACK && m_loss < 65535) m_loss++;
        if (nxt != m_st) begin
            m_lk = 0; m_ul = 0; m_to = 0;
            if (nxt == S_SEED) m_edges = 0;
        end
        m_st = nxt;
        h2 = h1; h1 = h0; h0 = ref_in;
    endfunction

    // ---------------- stimulus driver ----------------
    bit ref_run = 1'b0;
    int ph = 0;
    int per = 6;
    int lock_default = 1;   // 0/1 fixed, 2 = mostly locked at random
    int lock_q[$];
    bit cur_lock = 1'b1;
    int pin_rises = 0;

    task automatic drive();
        if (!ref_run) begin
            ref_in = 1'b0;
            ph = 0;
            pll_locked = 1'($urandom_range(0, 1));
        end else begin
            ph++;
            if (ph >= per) begin
                ph = 0;
                per = $urandom_range(5, 10);
                ref_in = 1'b1;
                pin_rises++;
                if (lock_q.size() > 0) cur_lock = lock_q.pop_front() != 0;
                else if (lock_default == 2) cur_lock = ($urandom_range(0, 7) != 0);
                else cur_lock = lock_default[0];
            end else if (ph >= 2) begin
                ref_in = 1'b0;
            end
            // Held around the cycle the DUT samples it; noise elsewhere.
            pll_locked = (ph <= 3) ? cur_lock : 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- per-cycle compare ----------------
    int ld_cnt = 0, last_ld = 0, prev_ld = 0;

    task automatic compare();
        if (rst) model_reset();
        chk("state",   int'(state),   m_st);
        chk("seed",    int'(seed),    m_seed);
        chk("seed_ld", int'(seed_ld), int'(m_st == S_SEED));
        chk("hold",    int'(hold),    int'(m_st == S_HOLD));
        chk("fine",    int'(fine),    int'(m_st == S_TRACK));
        chk("lock_ok", int'(lock_ok), int'(m_st == S_TRACK));
`ifdef PLL_SUP_LOSS_CNT_EN
        chk("loss_cnt", int'(loss_cnt), m_loss);
`endif
        if (seed_ld) begin
            ld_cnt++;
            prev_ld = last_ld;
            last_ld = int'(seed);
        end
    endtask

    initial begin : main_loop
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            #1;
            drive();
            @(negedge clk);
            compare();
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input int st, input int budget, input string nm);
        int i = 0;
        while (m_st != st && i < budget) begin
            @(negedge clk); #1; i++;
        end
        if (m_st != st) chk(nm, m_st, st);
    endtask

    task automatic wait_ld(input int n, input int budget, input string nm);
        int i = 0;
        while (ld_cnt < n && i < budget) begin
            @(negedge clk); #1; i++;
        end
        if (ld_cnt < n) chk(nm, ld_cnt, n);
    endtask

    task automatic wait_rises(input int n);
        int target = pin_rises + n;
        int i = 0;
        while (pin_rises < target && i < 12 * n + 20) begin
            @(negedge clk); #1; i++;
        end
        if (pin_rises < target) chk("rise_wait_timeout", pin_rises, target);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(state),   0);
        chk({tag, "_seed"},  int'(seed),    400);
        chk({tag, "_ld"},    int'(seed_ld), 0);
        chk({tag, "_hold"},  int'(hold),    0);
        chk({tag, "_fine"},  int'(fine),    0);
        chk({tag, "_lock"},  int'(lock_ok), 0);
    endtask

    initial begin : scenario
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst");

        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_after_release", int'(state), 0);
        @(negedge clk); #1;
        chk("first_seed_state", int'(state), 1);
        chk("first_seed_ld", int'(seed_ld), 1);
        chk("first_seed_val", int'(seed), 400);

        // Lock with every edge locked: 16 reference rises.
        lock_default = 1;
        pin_rises = 0;
        ref_run = 1'b1;
        wait_state(S_TRACK, 400, "t1_lock_timeout");
        chk("t1_rises_to_lock", pin_rises, 16);
        chk("t1_lock_ok", int'(lock_ok), 1);
        chk("t1_fine", int'(fine), 1);
        chk("t1_single_load", ld_cnt, 1);

        // Three unlocked edges then a locked one keep the lock.
        lock_q.push_back(0); lock_q.push_back(0); lock_q.push_back(0); lock_q.push_back(1);
        wait_rises(6);
        wait_cycles(4);
        chk("t3_lock_held", int'(lock_ok), 1);
        chk("t3_state_track", int'(state), 3);

        // Four consecutive unlocked edges drop the lock without a reload.
        lock_default = 0;
        lock_q.push_back(0); lock_q.push_back(0); lock_q.push_back(0); lock_q.push_back(0);
        wait_rises(4);
        wait_cycles(4);
        chk("t3_lock_lost", int'(lock_ok), 0);
        chk("t3_coarse", int'(fine), 0);
        chk("t3_state_acq", int'(state), 2);
        chk("t3_no_reload", ld_cnt, 1);
`ifdef PLL_SUP_LOSS_CNT_EN
        chk("t3_loss_cnt", int'(loss_cnt), 1);
`endif

        // Sweep: 425 first, then 800 is followed by 400.
        wait_ld(2, 400, "t2_first_step_timeout");
        chk("t2_seed_425", last_ld, 425);
        wait_ld(18, 5000, "t2_wrap_timeout");
        chk("t2_before_wrap", prev_ld, 800);
        chk("t2_wrap_400", last_ld, 400);
        wait_ld(22, 1500, "t5_seed500_timeout");
        chk("t5_seed_500", last_ld, 500);

        // Asynchronous reset mid-ACQUIRE.
        wait_rises(3);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_ld(23, 20, "t5_reload_timeout");
        chk("t5_restart_400", last_ld, 400);

        // Dropout in TRACK, then recovery on the first edge.
        lock_default = 1;
        wait_state(S_TRACK, 1000, "t4_lock_timeout");
        ref_run = 1'b0;
        wait_state(S_HOLD, P_TO + 50, "t4_dropout_timeout");
        chk("t4_hold", int'(hold), 1);
        chk("t4_lock_off", int'(lock_ok), 0);
        chk("t4_state_hold", int'(state), 4);
`ifdef PLL_SUP_LOSS_CNT_EN
        chk("t4_loss_cnt", int'(loss_cnt), 1);
`endif
        ref_run = 1'b1;
        wait_ld(24, 100, "t4_reseed_timeout");
        chk("t4_reseed_val", last_ld, 400);
        chk("t4_hold_clear", int'(hold), 0);

        // Randomized traffic: lock patterns, reference stops, occasional resets.
        for (int it = 0; it < 40; it++) begin
            lock_default = $urandom_range(0, 2);
            ref_run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 14) == 0) begin
                @(posedge clk); #3 rst = 1'b1;
                @(posedge clk); #2 rst = 1'b0;
            end
            wait_cycles($urandom_range(50, 600));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
